// File: rtl/axi_mem_responder_pkg.sv
// Shared types and constants for the AXI memory responder.
// No logic of its own; pure declarations plus the tie-break helper.
// Not applicable: holds no state and exerts no backpressure.
package axi_mem_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_DATA  = 3'd1,
        ST_W_RESP  = 3'd2,
        ST_R_FETCH = 3'd3,
        ST_R_DATA  = 3'd4
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Burst encodings; the responder treats every burst as INCR.
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // Write wins unless read is also requesting and write won the previous grant.
    function automatic logic tie_grant_wr(input logic awvalid, input logic arvalid,
                                          input logic last_wr);
        return awvalid & (~arvalid | ~last_wr);
    endfunction

endpackage

// File: rtl/axi_mem_responder_ram.sv
// Single-port byte-enable RAM; contents are never cleared by reset.
// Latency: read data registered, valid one cycle after en.
// Backpressure: none; dout holds its value whenever en is low.
module iob_ram_sp_be #(
    parameter int    DATA_W   = 32,
    parameter int    ADDR_W   = 16,
    parameter string HEX_FILE = "none"
) (
    input  logic                clk,
    input  logic                en,
    input  logic [DATA_W/8-1:0] we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Byte-masked write and read-before-write output register, both gated by en.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (we[b]) begin
                    mem[addr][b*8 +: 8] <= din[b*8 +: 8];
                end
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an internal RAM; one INCR burst at a time, always OKAY.
// Latency: write beats from handshake+1, B after last beat; read 2 cycles per beat.
// Backpressure: valids held until ready; FSM stalls in W_RESP/R_DATA indefinitely.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int    ADDR_W     = 32,
    parameter int    DATA_W     = 32,
    parameter int    MEM_ADDR_W = 16,
    parameter string HEX_FILE   = "none"
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                axi_awid,
    input  logic [ADDR_W-1:0]   axi_awaddr,
    input  logic [7:0]          axi_awlen,
    input  logic [2:0]          axi_awsize,
    input  logic [1:0]          axi_awburst,
    input  logic                axi_awlock,
    input  logic [3:0]          axi_awcache,
    input  logic [2:0]          axi_awprot,
    input  logic [3:0]          axi_awqos,
    input  logic                axi_awvalid,
    output logic                axi_awready,

    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic [DATA_W/8-1:0] axi_wstrb,
    input  logic                axi_wlast,
    input  logic                axi_wvalid,
    output logic                axi_wready,

    output logic                axi_bid,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready,

    input  logic                axi_arid,
    input  logic [ADDR_W-1:0]   axi_araddr,
    input  logic [7:0]          axi_arlen,
    input  logic [2:0]          axi_arsize,
    input  logic [1:0]          axi_arburst,
    input  logic                axi_arlock,
    input  logic [3:0]          axi_arcache,
    input  logic [2:0]          axi_arprot,
    input  logic [3:0]          axi_arqos,
    input  logic                axi_arvalid,
    output logic                axi_arready,

    output logic                axi_rid,
    output logic [DATA_W-1:0]   axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rlast,
    output logic                axi_rvalid,
    input  logic                axi_rready
);

    state_t                state;
    logic                  last_wr;
    logic                  id_q;
    logic [MEM_ADDR_W-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;

    logic                  idle;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  w_hs;
    logic                  ram_en;
    logic [DATA_W/8-1:0]   ram_we;
    logic [DATA_W-1:0]     ram_dout;

    // Size, burst type, QoS and friends do not affect behaviour; wlast is
    // ignored because the beat counter decides where a burst ends.
    logic unused_inputs;
    assign unused_inputs = ^{axi_awaddr, axi_awsize, axi_awburst, axi_awlock, axi_awcache,
                             axi_awprot, axi_awqos, axi_wlast, axi_araddr, axi_arsize,
                             axi_arburst, axi_arlock, axi_arcache, axi_arprot, axi_arqos};

    assign idle     = (state == ST_IDLE);
    assign grant_wr = tie_grant_wr(axi_awvalid, axi_arvalid, last_wr);
    assign grant_rd = ~grant_wr;

    assign axi_awready = idle & axi_awvalid & grant_wr;
    assign axi_arready = idle & axi_arvalid & grant_rd;

    assign axi_wready = (state == ST_W_DATA);
    assign w_hs       = axi_wready & axi_wvalid;

    assign axi_bvalid = (state == ST_W_RESP);
    assign axi_bid    = id_q;
    assign axi_bresp  = AXI_RESP_OKAY;

    // rdata is forced to zero outside R_DATA so the port reads 0 out of reset.
    assign axi_rvalid = (state == ST_R_DATA);
    assign axi_rdata  = axi_rvalid ? ram_dout : '0;
    assign axi_rid    = id_q;
    assign axi_rresp  = AXI_RESP_OKAY;
    assign axi_rlast  = axi_rvalid & (cnt_q == len_q);

    // RAM is only enabled on a write beat or the fetch cycle, keeping rdata stable in R_DATA.
    assign ram_we = w_hs ? axi_wstrb : '0;
    assign ram_en = w_hs | (state == ST_R_FETCH);

    iob_ram_sp_be #(
        .DATA_W   (DATA_W),
        .ADDR_W   (MEM_ADDR_W),
        .HEX_FILE (HEX_FILE)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (addr_q),
        .din  (axi_wdata),
        .dout (ram_dout)
    );

    // Transaction FSM: arbitration, address/beat tracking and burst termination.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            last_wr <= 1'b0;
            id_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (axi_awready) begin
                        id_q    <= axi_awid;
                        addr_q  <= axi_awaddr[MEM_ADDR_W+1:2];
                        len_q   <= axi_awlen;
                        cnt_q   <= '0;
                        last_wr <= 1'b1;
                        state   <= ST_W_DATA;
                    end else if (axi_arready) begin
                        id_q    <= axi_arid;
                        addr_q  <= axi_araddr[MEM_ADDR_W+1:2];
                        len_q   <= axi_arlen;
                        cnt_q   <= '0;
                        last_wr <= 1'b0;
                        state   <= ST_R_FETCH;
                    end
                end
                ST_W_DATA: begin
                    if (axi_wvalid) begin
                        addr_q <= addr_q + MEM_ADDR_W'(1);
                        cnt_q  <= cnt_q + 8'd1;
                        if (cnt_q == len_q) begin
                            state <= ST_W_RESP;
                        end
                    end
                end
                ST_W_RESP: begin
                    if (axi_bready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_R_FETCH: begin
                    state <= ST_R_DATA;
                end
                ST_R_DATA: begin
                    if (axi_rready) begin
                        if (axi_rlast) begin
                            state <= ST_IDLE;
                        end else begin
                            addr_q <= addr_q + MEM_ADDR_W'(1);
                            cnt_q  <= cnt_q + 8'd1;
                            state  <= ST_R_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed testbench for axi_mem_responder with a 16-word RAM.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Every wait on the DUT is bounded and a timeout is reported as a failure.
module tb_axi_mem_responder;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              awid, awlock, awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize, awprot;
    logic [1:0]        awburst;
    logic [3:0]        awcache, awqos;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast, wvalid, wready;
    logic              bid, bvalid, bready;
    logic [1:0]        bresp;
    logic              arid, arlock, arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize, arprot;
    logic [1:0]        arburst;
    logic [3:0]        arcache, arqos;
    logic              rid, rlast, rvalid, rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wbuf      [0:255];
    logic [3:0]  sbuf      [0:255];
    logic [31:0] rbuf      [0:255];
    logic        rlast_buf [0:255];

    always #5 clk = ~clk;

    axi_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W), .HEX_FILE("none")
    ) dut (
        .clk(clk), .rst(rst),
        .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
        .axi_awburst(awburst), .axi_awlock(awlock), .axi_awcache(awcache),
        .axi_awprot(awprot), .axi_awqos(awqos), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
        .axi_wready(wready),
        .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize),
        .axi_arburst(arburst), .axi_arlock(arlock), .axi_arcache(arcache),
        .axi_arprot(arprot), .axi_arqos(arqos), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast),
        .axi_rvalid(rvalid), .axi_rready(rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write transaction; reports B fields, cycles from last beat to bvalid, timeout.
    task automatic write_txn(input logic [31:0] addr, input logic [7:0] len, input logic id,
                             input bit gaps, output logic [1:0] bresp_o, output logic bid_o,
                             output int blat, output bit to);
        int k;
        to = 1'b0; blat = -1; bresp_o = 2'b11; bid_o = ~id;
        awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!awready && k < 50) begin @(negedge clk); k++; end
        if (!awready) begin to = 1'b1; awvalid = 1'b0; return; end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps && (i % 2 == 1)) begin wvalid = 1'b0; tick(); end
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == int'(len));
            k = 0;
            @(negedge clk);
            while (!wready && k < 50) begin @(negedge clk); k++; end
            if (!wready) begin to = 1'b1; wvalid = 1'b0; return; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        blat = 1;
        @(negedge clk);
        while (!bvalid && blat < 50) begin @(negedge clk); blat++; end
        if (!bvalid) begin to = 1'b1; bready = 1'b0; return; end
        bresp_o = bresp; bid_o = bid;
        tick();
        bready = 1'b0;
    endtask

    // Full read transaction into rbuf/rlast_buf; stall holds rready low two cycles in three.
    task automatic read_txn(input logic [31:0] addr, input logic [7:0] len, input logic id,
                            input bit stall, output int lat, output logic rid_o,
                            output int nbeats, output bit to);
        int k;
        to = 1'b0; lat = 0; nbeats = 0; rid_o = ~id;
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!arready && k < 50) begin @(negedge clk); k++; end
        if (!arready) begin to = 1'b1; arvalid = 1'b0; return; end
        tick();
        arvalid = 1'b0;
        k = 0;
        rready = stall ? 1'b0 : 1'b1;
        while (nbeats <= int'(len) && k < 2000) begin
            @(negedge clk);
            if (rvalid && lat == 0) lat = k + 1;
            if (rvalid && rready) begin
                rbuf[nbeats] = rdata; rlast_buf[nbeats] = rlast; rid_o = rid;
                nbeats++;
            end
            tick();
            k++;
            rready = stall ? (k % 3 == 2) : 1'b1;
        end
        rready = 1'b0;
        to = (nbeats <= int'(len));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_checks++; if (awready !== 1'b0) $display("FAIL reset_awready: got %b expected 0", awready); else n_pass++;
        n_checks++; if (wready !== 1'b0) $display("FAIL reset_wready: got %b expected 0", wready); else n_pass++;
        n_checks++; if (bvalid !== 1'b0) $display("FAIL reset_bvalid: got %b expected 0", bvalid); else n_pass++;
        n_checks++; if (bid !== 1'b0) $display("FAIL reset_bid: got %b expected 0", bid); else n_pass++;
        n_checks++; if (bresp !== 2'b00) $display("FAIL reset_bresp: got %b expected 00", bresp); else n_pass++;
        n_checks++; if (arready !== 1'b0) $display("FAIL reset_arready: got %b expected 0", arready); else n_pass++;
        n_checks++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b expected 0", rvalid); else n_pass++;
        n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else n_pass++;
        n_checks++; if (rid !== 1'b0) $display("FAIL reset_rid: got %b expected 0", rid); else n_pass++;
        n_checks++; if (rlast !== 1'b0) $display("FAIL reset_rlast: got %b expected 0", rlast); else n_pass++;
        n_checks++; if (rresp !== 2'b00) $display("FAIL reset_rresp: got %b expected 00", rresp); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [1:0] br; logic bi, ri; int bl, lat, nb; bit to;
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        write_txn(32'h10, 8'd0, 1'b1, 1'b0, br, bi, bl, to);
        n_checks++; if (to !== 1'b0) $display("FAIL single_wr_timeout: got %b expected 0", to); else n_pass++;
        n_checks++; if (br !== 2'b00) $display("FAIL single_bresp: got %b expected 00", br); else n_pass++;
        n_checks++; if (bi !== 1'b1) $display("FAIL single_bid: got %b expected 1", bi); else n_pass++;
        n_checks++; if (bl !== 1) $display("FAIL single_b_latency: got %0d expected 1", bl); else n_pass++;
        read_txn(32'h10, 8'd0, 1'b1, 1'b0, lat, ri, nb, to);
        n_checks++; if (to !== 1'b0) $display("FAIL single_rd_timeout: got %b expected 0", to); else n_pass++;
        n_checks++; if (rbuf[0] !== 32'hDEADBEEF) $display("FAIL single_rdata: got %h expected deadbeef", rbuf[0]); else n_pass++;
        n_checks++; if (rlast_buf[0] !== 1'b1) $display("FAIL single_rlast: got %b expected 1", rlast_buf[0]); else n_pass++;
        n_checks++; if (ri !== 1'b1) $display("FAIL single_rid: got %b expected 1", ri); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL single_r_latency: got %0d expected 2", lat); else n_pass++;
    endtask

    task automatic test_strobes();
        logic [1:0] br; logic bi, ri; int bl, lat, nb; bit to1, to2, to3;
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        write_txn(32'h14, 8'd0, 1'b0, 1'b0, br, bi, bl, to1);
        wbuf[0] = 32'h00000000; sbuf[0] = 4'h5;
        write_txn(32'h14, 8'd0, 1'b0, 1'b0, br, bi, bl, to2);
        read_txn(32'h14, 8'd0, 1'b0, 1'b0, lat, ri, nb, to3);
        n_checks++; if ((to1 | to2 | to3) !== 1'b0) $display("FAIL strobe_timeout: got %b%b%b expected 000", to1, to2, to3); else n_pass++;
        n_checks++; if (rbuf[0] !== 32'hFF00FF00) $display("FAIL strobe_rdata: got %h expected ff00ff00", rbuf[0]); else n_pass++;
    endtask

    task automatic test_burst();
        logic [1:0] br; logic bi, ri; int bl, lat, nb; bit to;
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hA0000000 + i; sbuf[i] = 4'hF; end
        write_txn(32'h20, 8'd7, 1'b1, 1'b1, br, bi, bl, to);
        n_checks++; if (to !== 1'b0) $display("FAIL burst_wr_timeout: got %b expected 0", to); else n_pass++;
        n_checks++; if (bl !== 1) $display("FAIL burst_b_latency: got %0d expected 1", bl); else n_pass++;
        read_txn(32'h20, 8'd7, 1'b0, 1'b1, lat, ri, nb, to);
        n_checks++; if (nb !== 8) $display("FAIL burst_rd_beats: got %0d expected 8", nb); else n_pass++;
        n_checks++; if (ri !== 1'b0) $display("FAIL burst_rid: got %b expected 0", ri); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (rbuf[i] !== 32'hA0000000 + i) $display("FAIL burst_rdata[%0d]: got %h expected %h", i, rbuf[i], 32'hA0000000 + i); else n_pass++;
            n_checks++; if (rlast_buf[i] !== (i == 7)) $display("FAIL burst_rlast[%0d]: got %b expected %b", i, rlast_buf[i], (i == 7)); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [1:0] br; logic bi, ri; int bl, lat, nb; bit to;
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0DE0000 + i; sbuf[i] = 4'hF; end
        write_txn(32'h38, 8'd3, 1'b0, 1'b0, br, bi, bl, to);
        n_checks++; if (to !== 1'b0) $display("FAIL wrap_wr_timeout: got %b expected 0", to); else n_pass++;
        read_txn(32'h38, 8'd3, 1'b0, 1'b0, lat, ri, nb, to);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rbuf[i] !== 32'hC0DE0000 + i) $display("FAIL wrap_rdata[%0d]: got %h expected %h", i, rbuf[i], 32'hC0DE0000 + i); else n_pass++;
        end
        read_txn(32'h00, 8'd1, 1'b0, 1'b0, lat, ri, nb, to);
        n_checks++; if (rbuf[0] !== 32'hC0DE0002) $display("FAIL wrap_word0: got %h expected c0de0002", rbuf[0]); else n_pass++;
        n_checks++; if (rbuf[1] !== 32'hC0DE0003) $display("FAIL wrap_word1: got %h expected c0de0003", rbuf[1]); else n_pass++;
        read_txn(32'h20, 8'd0, 1'b0, 1'b0, lat, ri, nb, to);
        n_checks++; if (rbuf[0] !== 32'hA0000000) $display("FAIL wrap_word8_intact: got %h expected a0000000", rbuf[0]); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int ngrant, overlap;
        logic [3:0] seq;
        logic [31:0] first_rdata;
        logic first_rid;
        bit got_r;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        ngrant = 0; overlap = 0; seq = 4'h0; got_r = 1'b0; first_rdata = 32'h0; first_rid = 1'b0;
        awaddr = 32'h0C; awlen = 8'd0; awid = 1'b0; awvalid = 1'b1;
        araddr = 32'h0C; arlen = 8'd0; arid = 1'b1; arvalid = 1'b1;
        wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        for (int k = 0; k < 80 && ngrant < 4; k++) begin
            @(negedge clk);
            if (awready && arready) overlap++;
            if (awready) begin seq[ngrant] = 1'b1; ngrant++; end
            else if (arready) begin seq[ngrant] = 1'b0; ngrant++; end
            if (rvalid && !got_r) begin got_r = 1'b1; first_rdata = rdata; first_rid = rid; end
            tick();
            if (ngrant == 4) begin awvalid = 1'b0; arvalid = 1'b0; end
        end
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (awready && arready) overlap++;
            tick();
        end
        bready = 1'b0; rready = 1'b0;
        n_checks++; if (ngrant !== 4) $display("FAIL simul_grant_count: got %0d expected 4", ngrant); else n_pass++;
        n_checks++; if (seq !== 4'b0101) $display("FAIL simul_grant_order: got %b expected 0101 (bit0 first, 1=W)", seq); else n_pass++;
        n_checks++; if (overlap !== 0) $display("FAIL simul_ready_overlap: got %0d expected 0", overlap); else n_pass++;
        n_checks++; if (first_rdata !== 32'h5A5A5A5A) $display("FAIL simul_rdata: got %h expected 5a5a5a5a", first_rdata); else n_pass++;
        n_checks++; if (first_rid !== 1'b1) $display("FAIL simul_rid: got %b expected 1", first_rid); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic ri; int lat, nb, k; bit to;
        araddr = 32'h10; arlen = 8'd3; arid = 1'b1; arvalid = 1'b1; rready = 1'b0;
        k = 0;
        @(negedge clk);
        while (!arready && k < 50) begin @(negedge clk); k++; end
        tick();
        arvalid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!rvalid && k < 50) begin @(negedge clk); k++; end
        n_checks++; if (rvalid !== 1'b1) $display("FAIL rstmid_reach_rdata: got %b expected 1", rvalid); else n_pass++;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rvalid !== 1'b0) $display("FAIL rstmid_rvalid: got %b expected 0", rvalid); else n_pass++;
        n_checks++; if (rdata !== 32'h0) $display("FAIL rstmid_rdata: got %h expected 0", rdata); else n_pass++;
        tick();
        read_txn(32'h10, 8'd0, 1'b0, 1'b0, lat, ri, nb, to);
        n_checks++; if (to !== 1'b0) $display("FAIL rstmid_rd_timeout: got %b expected 0", to); else n_pass++;
        n_checks++; if (rbuf[0] !== 32'hDEADBEEF) $display("FAIL rstmid_rdata_after: got %h expected deadbeef", rbuf[0]); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        awid = 1'b0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awlock = 1'b0;
        awcache = '0; awprot = '0; awqos = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 1'b0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arlock = 1'b0;
        arcache = '0; arprot = '0; arqos = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_single();
        test_strobes();
        test_burst();
        test_wrap();
        test_simultaneous();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
